axis_dot_arbiter: RTL
=====================

Name: axis_dot_arbiter

Overview:
- Shares one dot-product engine (dot_40_20 via its AXI4-Stream wrapper) between two AXI4-Stream requesters.
- Grants one complete input packet (up to TLAST) to one requester and forwards it to the engine.
- Routes the engine's complete result packet back to that requester's output stream, then re-arbitrates round-robin.
- Sits between the DMA-facing stream ports and the engine in the accelerator datapath.

Parameters:
- DATA_W, 32, stream data width; must match the engine.
- CNT_W, 16, width of the per-requester completed-job counters (optional feature only).

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous assert, active-low
- S0_AXIS_TDATA/TLAST/TVALID  in  DATA_W/1/1  requester 0 input stream
- S0_AXIS_TREADY  out  1  requester 0 ready
- S1_AXIS_TDATA/TLAST/TVALID  in  DATA_W/1/1  requester 1 input stream
- S1_AXIS_TREADY  out  1  requester 1 ready
- ENG_IN_AXIS_TDATA/TLAST/TVALID  out  DATA_W/1/1  stream to engine input
- ENG_IN_AXIS_TREADY  in  1  engine input ready
- ENG_OUT_AXIS_TDATA/TLAST/TVALID  in  DATA_W/1/1  engine result stream
- ENG_OUT_AXIS_TREADY  out  1  engine result ready
- M0_AXIS_TDATA/TLAST/TVALID  out  DATA_W/1/1  result stream to requester 0
- M0_AXIS_TREADY  in  1
- M1_AXIS_TDATA/TLAST/TVALID  out  DATA_W/1/1  result stream to requester 1
- M1_AXIS_TREADY  in  1
- busy  out  1  high in FEED or COLLECT
- owner  out  1  index of the granted requester (valid while busy)
- done_cnt0, done_cnt1  out  CNT_W each  completed jobs per requester (see Optional Feature)

Behaviour:
- Reset (aresetn low, async): state=IDLE, owner=0, last_grant=1 (requester 0 wins first). All TREADY/TVALID outputs 0. Counters 0.
- A reset mid-packet aborts the job and returns to IDLE. The engine shares aresetn, so no partial result survives.
- State IDLE:
  - All TREADY=0, all TVALID=0.
  - Only one S*_TVALID high: grant that requester.
  - Both high: grant the requester != last_grant.
  - On grant: register owner, go to FEED next cycle (1-cycle arbitration bubble).
- State FEED:
  - ENG_IN_* = S[owner]_* combinationally; S[owner]_TREADY = ENG_IN_AXIS_TREADY.
  - Other requester TREADY=0.
  - ENG_OUT_AXIS_TREADY=0; engine results are held off.
  - Handshake with TLAST=1 -> COLLECT.
- State COLLECT:
  - M[owner]_* = ENG_OUT_* combinationally; ENG_OUT_AXIS_TREADY = M[owner]_TREADY.
  - Other M TVALID=0; both S TREADY=0.
  - Handshake with TLAST=1 -> IDLE; last_grant<=owner.
- Beats pass through with zero added latency; no data buffering. Throughput is one beat/cycle whenever both sides are ready.
- Grant is sticky for the whole job:
  - a requester dropping TVALID mid-packet stalls the job; it does not abort it;
  - the other requester waits regardless of its TVALID.
- TDATA/TLAST on unselected outputs are driven 0.
- busy=1 in FEED and COLLECT; owner is constant from grant until return to IDLE.
- A 1-beat input packet (TLAST on first beat) is legal: FEED lasts one handshake cycle.
- Back-to-back jobs: minimum one IDLE cycle between a COLLECT TLAST and the next FEED.

Optional Feature:
- Macro: AXIS_DOT_ARB_STATS_EN.
- Defined:
  - done_cnt0/done_cnt1 increment by 1 on the COLLECT TLAST handshake for the owner.
  - Counters wrap 0xFFFF->0 (for CNT_W=16) and clear only on reset.
- Undefined: counters not instantiated; done_cnt0/done_cnt1 tied to 0.
- Port list is identical either way.

Test Plan:
- Reset/idle: aresetn=0 then 1, no traffic -> all TREADY/TVALID 0, busy=0, counters 0.
- Single job: S0 sends 40 beats 1..40 (TLAST on 40); engine model returns 20 beats 0x100..0x113.
  - Expect ENG_IN to see 1..40 in order.
  - Expect M0 to receive 0x100..0x113 with TLAST on 0x113; M1_TVALID never 1.
  - Expect done_cnt0=1 with STATS_EN.
- Contention: S0 and S1 both valid from reset -> S0 served first, then S1, then S0.
  - No interleaving of S0/S1 beats on ENG_IN.
  - Each result lands only on its owner's M port.
- Backpressure: M1_TREADY toggles 1-0 every cycle during S1's result -> all 20 beats delivered, none duplicated or dropped.
  - ENG_OUT_AXIS_TREADY mirrors M1_TREADY.
- Stall and abort: S0 drops TVALID for 5 cycles after beat 10 -> grant kept, S1_TREADY stays 0.
  - Then aresetn=0 mid-FEED -> next cycle all outputs 0, state IDLE, next grant goes to S0.
- Counter wrap (STATS_EN, CNT_W=2 override): 5 S1 jobs -> done_cnt1 sequence 1,2,3,0,1.

Source files
------------

// File: rtl/axis_dot_arbiter.sv
// Round-robin packet arbiter sharing one AXI4-Stream dot-product engine.
// Optional per-requester job counters: define AXIS_DOT_ARB_STATS_EN.
module axis_dot_arbiter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [DATA_W-1:0] S0_AXIS_TDATA,
   input  logic              S0_AXIS_TLAST,
   input  logic              S0_AXIS_TVALID,
   output logic              S0_AXIS_TREADY,
   input  logic [DATA_W-1:0] S1_AXIS_TDATA,
   input  logic              S1_AXIS_TLAST,
   input  logic              S1_AXIS_TVALID,
   output logic              S1_AXIS_TREADY,
   output logic [DATA_W-1:0] ENG_IN_AXIS_TDATA,
   output logic              ENG_IN_AXIS_TLAST,
   output logic              ENG_IN_AXIS_TVALID,
   input  logic              ENG_IN_AXIS_TREADY,
   input  logic [DATA_W-1:0] ENG_OUT_AXIS_TDATA,
   input  logic              ENG_OUT_AXIS_TLAST,
   input  logic              ENG_OUT_AXIS_TVALID,
   output logic              ENG_OUT_AXIS_TREADY,
   output logic [DATA_W-1:0] M0_AXIS_TDATA,
   output logic              M0_AXIS_TLAST,
   output logic              M0_AXIS_TVALID,
   input  logic              M0_AXIS_TREADY,
   output logic [DATA_W-1:0] M1_AXIS_TDATA,
   output logic              M1_AXIS_TLAST,
   output logic              M1_AXIS_TVALID,
   input  logic              M1_AXIS_TREADY,
   output logic              busy,
   output logic              owner,
   output logic [CNT_W-1:0]  done_cnt0,
   output logic [CNT_W-1:0]  done_cnt1
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FEED    = 2'd1,
      COLLECT = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   owner_q, owner_d;
   logic   last_q, last_d;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      owner_d             = owner_q;
      last_d              = last_q;
      S0_AXIS_TREADY      = 1'b0;
      S1_AXIS_TREADY      = 1'b0;
      ENG_IN_AXIS_TDATA   = '0;
      ENG_IN_AXIS_TLAST   = 1'b0;
      ENG_IN_AXIS_TVALID  = 1'b0;
      ENG_OUT_AXIS_TREADY = 1'b0;
      M0_AXIS_TDATA       = '0;
      M0_AXIS_TLAST       = 1'b0;
      M0_AXIS_TVALID      = 1'b0;
      M1_AXIS_TDATA       = '0;
      M1_AXIS_TLAST       = 1'b0;
      M1_AXIS_TVALID      = 1'b0;
      unique case (state_q)
         IDLE: begin
            // On contention the requester that did not win last time goes
            if (S0_AXIS_TVALID || S1_AXIS_TVALID) begin
               owner_d = (S0_AXIS_TVALID && S1_AXIS_TVALID) ?
                         ~last_q : ~S0_AXIS_TVALID;
               state_d = FEED;
            end
         end
         FEED: begin
            if (owner_q) begin
               ENG_IN_AXIS_TDATA  = S1_AXIS_TDATA;
               ENG_IN_AXIS_TLAST  = S1_AXIS_TLAST;
               ENG_IN_AXIS_TVALID = S1_AXIS_TVALID;
               S1_AXIS_TREADY     = ENG_IN_AXIS_TREADY;
            end else begin
               ENG_IN_AXIS_TDATA  = S0_AXIS_TDATA;
               ENG_IN_AXIS_TLAST  = S0_AXIS_TLAST;
               ENG_IN_AXIS_TVALID = S0_AXIS_TVALID;
               S0_AXIS_TREADY     = ENG_IN_AXIS_TREADY;
            end
            if (ENG_IN_AXIS_TVALID && ENG_IN_AXIS_TREADY &&
                ENG_IN_AXIS_TLAST)
               state_d = COLLECT;
         end
         COLLECT: begin
            if (owner_q) begin
               M1_AXIS_TDATA       = ENG_OUT_AXIS_TDATA;
               M1_AXIS_TLAST       = ENG_OUT_AXIS_TLAST;
               M1_AXIS_TVALID      = ENG_OUT_AXIS_TVALID;
               ENG_OUT_AXIS_TREADY = M1_AXIS_TREADY;
            end else begin
               M0_AXIS_TDATA       = ENG_OUT_AXIS_TDATA;
               M0_AXIS_TLAST       = ENG_OUT_AXIS_TLAST;
               M0_AXIS_TVALID      = ENG_OUT_AXIS_TVALID;
               ENG_OUT_AXIS_TREADY = M0_AXIS_TREADY;
            end
            if (ENG_OUT_AXIS_TVALID && ENG_OUT_AXIS_TREADY &&
                ENG_OUT_AXIS_TLAST) begin
               state_d = IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy  = (state_q != IDLE);
   assign owner = owner_q;

`ifdef AXIS_DOT_ARB_STATS_EN
   logic             job_done;
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   assign job_done = (state_q == COLLECT) && ENG_OUT_AXIS_TVALID &&
                     ENG_OUT_AXIS_TREADY && ENG_OUT_AXIS_TLAST;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (job_done) begin
         if (owner_q) cnt1_q <= cnt1_q + CNT_W'(1);
         else         cnt0_q <= cnt0_q + CNT_W'(1);
      end
   end

   assign done_cnt0 = cnt0_q;
   assign done_cnt1 = cnt1_q;
`else
   assign done_cnt0 = '0;
   assign done_cnt1 = '0;
`endif

endmodule
